// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: program counter, ROM fetch issue, little-endian word assembly and valid/ready delivery.
// Optional macro FETCH_SKID_EN adds one skid entry so fetch can sustain one instruction per cycle.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h8000,
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter logic [15:0] ROM_LAST = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] a,
  output logic        re,
  input  logic [7:0]  q0,
  input  logic [7:0]  q1,
  input  logic [7:0]  q2,
  input  logic [7:0]  q3,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [31:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fault,
  output logic [15:0] fault_pc
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_FAULT = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] inflight_pc;
  logic        inflight;

  logic        in_range;
  logic        xfer;
  logic        slot;
  logic        issue;
  logic [31:0] rom_word;

  assign rom_word = {q3, q2, q1, q0};
  assign in_range = (pc >= ROM_BASE) && (pc <= ROM_LAST);
  assign xfer     = instr_valid & instr_ready;

`ifdef FETCH_SKID_EN
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [15:0] skid_pc;
  logic [1:0]  occupancy;

  // Entries held or on their way, counting the one leaving this cycle as already gone.
  assign occupancy = {1'b0, instr_valid} + {1'b0, skid_valid} + {1'b0, inflight} - {1'b0, xfer};
  assign slot      = (occupancy < 2'd2);
`else
  assign slot = !inflight && (!instr_valid || instr_ready);
`endif

  // Gating with rst_n keeps re low while reset is held.
  assign issue = rst_n && (state == S_FETCH) && in_range && !redirect && slot;
  assign a     = pc;
  assign re    = issue;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
      instr       <= 32'h0000_0000;
      instr_pc    <= 16'h0000;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
      fault_pc    <= 16'h0000;
`ifdef FETCH_SKID_EN
      skid_valid  <= 1'b0;
      skid_instr  <= 32'h0000_0000;
      skid_pc     <= 16'h0000;
`endif
    end else if (redirect) begin
      state       <= S_FETCH;
      pc          <= redirect_pc;
      inflight    <= 1'b0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_valid  <= 1'b0;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        pc          <= pc + 16'd4;
        inflight_pc <= pc;
      end

      // Fault only once nothing is outstanding, so the last good response still lands.
      if ((state == S_FETCH) && !in_range && !inflight) begin
        state    <= S_FAULT;
        fault    <= 1'b1;
        fault_pc <= pc;
      end

`ifdef FETCH_SKID_EN
      if (xfer && skid_valid) begin
        instr    <= skid_instr;
        instr_pc <= skid_pc;
        if (inflight) begin
          skid_instr <= rom_word;
          skid_pc    <= inflight_pc;
        end else begin
          skid_valid <= 1'b0;
        end
      end else if (inflight) begin
        if (!instr_valid || xfer) begin
          instr       <= rom_word;
          instr_pc    <= inflight_pc;
          instr_valid <= 1'b1;
        end else begin
          skid_instr <= rom_word;
          skid_pc    <= inflight_pc;
          skid_valid <= 1'b1;
        end
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
`else
      if (inflight) begin
        instr       <= rom_word;
        instr_pc    <= inflight_pc;
        instr_valid <= 1'b1;
      end else if (xfer) begin
        instr_valid <= 1'b0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed stimulus, registered ROM model and a queue-based fetch model compared every cycle.
module tb_fetch_unit;

  localparam logic [15:0] RESET_PC = 16'h8000;
  localparam logic [15:0] ROM_BASE = 16'h8000;
  localparam logic [15:0] ROM_LAST = 16'hFFFC;
`ifdef FETCH_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a;
  logic        re;
  logic [7:0]  q0 = 8'h00, q1 = 8'h00, q2 = 8'h00, q3 = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic        fault;
  logic [15:0] fault_pc;

  int errors = 0;
  int checks = 0;

  fetch_unit #(.RESET_PC(RESET_PC), .ROM_BASE(ROM_BASE), .ROM_LAST(ROM_LAST)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .re(re),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] addr);
    return (addr[7:0] + 8'd1) ^ (addr[15:8] ^ 8'h80);
  endfunction

  function automatic logic [31:0] rom_word(input logic [15:0] addr);
    return {rom_byte(addr + 16'd3), rom_byte(addr + 16'd2), rom_byte(addr + 16'd1), rom_byte(addr)};
  endfunction

  function automatic bit in_win(input logic [15:0] p);
    return (p >= ROM_BASE) && (p <= ROM_LAST);
  endfunction

  always @(posedge clk) begin
    if (re) begin
      q0 <= rom_byte(a);
      q1 <= rom_byte(a + 16'd1);
      q2 <= rom_byte(a + 16'd2);
      q3 <= rom_byte(a + 16'd3);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of captured words of depth CAP plus one outstanding ROM read.
  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } entry_t;

  entry_t      outq[$];
  logic [15:0] m_pc = RESET_PC;
  logic [15:0] m_infl_pc = 16'h0000;
  logic [15:0] m_fault_pc = 16'h0000;
  bit          m_infl = 1'b0;
  bit          m_fault = 1'b0;

  always @(negedge clk) begin
    bit e_re;
    bit xf;
    int occ;
    if (!rst_n) begin
      m_pc = RESET_PC;
      m_infl = 1'b0;
      m_fault = 1'b0;
      m_fault_pc = 16'h0000;
      outq.delete();
      check("rst_a", 32'(a), 32'(RESET_PC));
      check("rst_re", 32'(re), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_fault", 32'(fault), 32'd0);
    end else begin
      xf    = (outq.size() > 0) && instr_ready;
      occ   = outq.size() + int'(m_infl) - int'(xf);
      e_re  = !m_fault && in_win(m_pc) && !redirect && (occ < CAP);
      check("a", 32'(a), 32'(m_pc));
      check("re", 32'(re), 32'(e_re));
      check("valid", 32'(instr_valid), 32'(outq.size() > 0));
      if (outq.size() > 0) begin
        check("instr", instr, outq[0].data);
        check("instr_pc", 32'(instr_pc), 32'(outq[0].pc));
      end
      check("fault", 32'(fault), 32'(m_fault));
      if (m_fault) check("fault_pc", 32'(fault_pc), 32'(m_fault_pc));

      if (redirect) begin
        m_pc = redirect_pc;
        m_infl = 1'b0;
        m_fault = 1'b0;
        outq.delete();
      end else begin
        if (xf) void'(outq.pop_front());
        if (m_infl) outq.push_back('{pc: m_infl_pc, data: rom_word(m_infl_pc)});
        if (!m_fault && !in_win(m_pc) && !m_infl) begin
          m_fault = 1'b1;
          m_fault_pc = m_pc;
        end
        m_infl = e_re;
        if (e_re) begin
          m_infl_pc = m_pc;
          m_pc = m_pc + 16'd4;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_re(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = (re === 1'b1);
    end
    if (!seen) check(name, 32'(re), 32'd1);
  endtask

  task automatic wait_valid_pc(input string name, input logic [15:0] pc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (instr_valid === 1'b1) && (instr_pc === pc);
    end
    if (!seen) check(name, 32'(instr_pc), 32'(pc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("reset_instr", instr, 32'h0000_0000);
    check("reset_instr_pc", 32'(instr_pc), 32'h0);
    check("reset_fault_pc", 32'(fault_pc), 32'h0);
    check("reset_a", 32'(a), 32'h8000);
    check("reset_re", 32'(re), 32'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("c0_a", 32'(a), 32'h8000);
    check("c0_re", 32'(re), 32'd1);
    step();
    step();
    @(negedge clk);
    check("c2_instr", instr, 32'h0403_0201);
    check("c2_instr_pc", 32'(instr_pc), 32'h8000);
    check("c2_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_SKID_EN
    step();
    @(negedge clk);
    check("seq_8004", 32'(instr_pc), 32'h8004);
    step();
    @(negedge clk);
    check("seq_8008", 32'(instr_pc), 32'h8008);
`else
    step();
    step();
    @(negedge clk);
    check("seq_8004", 32'(instr_pc), 32'h8004);
    step();
    step();
    @(negedge clk);
    check("seq_8008", 32'(instr_pc), 32'h8008);
`endif

    step();
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) check("stall_re", 32'(re), 32'd0);
      step();
    end
    instr_ready = 1'b1;
    repeat (6) step();

    // Redirect in the cycle after an issue: the returning bytes must be dropped.
    wait_re("redir_wait_re");
    step();
    redirect = 1'b1;
    redirect_pc = 16'h9000;
    step();
    redirect = 1'b0;
    wait_valid_pc("redir_first_pc", 16'h9000);
    check("redir_instr", instr, 32'h1413_1211);

    step();
    redirect = 1'b1;
    redirect_pc = 16'hFFF0;
    step();
    redirect = 1'b0;
    wait_valid_pc("top_pc", 16'hFFFC);
    check("top_instr", instr, 32'h7F80_8182);
    step();
    @(negedge clk);
    check("top_fault", 32'(fault), 32'd1);
    check("top_fault_pc", 32'(fault_pc), 32'h0000);
    check("top_re", 32'(re), 32'd0);

    step();
    redirect = 1'b1;
    redirect_pc = 16'h8000;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("clear_fault", 32'(fault), 32'd0);
    check("resume_re", 32'(re), 32'd1);
    repeat (4) step();

    redirect = 1'b1;
    redirect_pc = 16'h1000;
    step();
    redirect = 1'b0;
    @(negedge clk);
    check("oor_a", 32'(a), 32'h1000);
    check("oor_re", 32'(re), 32'd0);
    check("oor_fault_early", 32'(fault), 32'd0);
    step();
    @(negedge clk);
    check("oor_fault", 32'(fault), 32'd1);
    check("oor_fault_pc", 32'(fault_pc), 32'h1000);

    step();
    redirect = 1'b1;
    redirect_pc = 16'h8000;
    step();
    redirect = 1'b0;
    repeat (3) step();
    wait_re("arst_wait_re");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", 32'(a), 32'h8000);
    check("arst_re", 32'(re), 32'd0);
    check("arst_valid", 32'(instr_valid), 32'd0);
    check("arst_instr", instr, 32'h0000_0000);
    check("arst_fault", 32'(fault), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
